// File: rtl/stage_if_fetch_pkg.sv
// Shared types for the instruction-fetch front end: fetch FSM states,
// the buffered {pc, inst} entry, and PC helpers.
package stage_if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_if_fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; clear wins over push/pop.
module fetch_fifo
    import stage_if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      clear_i,
    input  fetch_entry_t              data_i,
    output fetch_entry_t              head_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic           do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push_i && !clear_i;
        do_pop   = pop_i && !clear_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/stage_if_fetch.sv
// Instruction-fetch front end: owns the PC, drives a single-outstanding
// req/ack memory port, buffers results and handles redirects.
module stage_if_fetch
    import stage_if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o
);

    localparam int          CW      = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    fetch_entry_t  hold_q, hold_d;
    fetch_entry_t  head;
    logic [CW:0]   count, count_next;
    logic          push, pop, empty, ack_seen, can_issue;
    logic [31:0]   flush_target;

    // pc_q is the next PC to fetch; in DROP it is the saved redirect target.
    always_comb begin
        flush_target = word_align(flush_pc_i);
        empty        = (count == '0);
        ack_seen     = (state_q != FETCH_IDLE) && mem_ack_i;
        push         = (state_q == FETCH_REQ) && mem_ack_i && !flush_i;
        pop          = !empty && out_ready_i && !flush_i;
        count_next   = count + (CW+1)'(push) - (CW+1)'(pop);
        can_issue    = ((state_q == FETCH_IDLE) || ack_seen) && (count_next < DEPTH_C);
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        hold_d       = empty ? hold_q : head;
        if (flush_i) begin
            pc_d = flush_target;
            if ((state_q != FETCH_IDLE) && !mem_ack_i) begin
                state_d = FETCH_DROP;
            end else begin
                state_d = FETCH_REQ;
                req_d   = 1'b1;
                addr_d  = flush_target;
            end
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (can_issue) begin
                        state_d = FETCH_REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                FETCH_REQ: begin
                    if (mem_ack_i) begin
                        pc_d = addr_q + 32'd4;
                        if (can_issue) begin
                            addr_d = addr_q + 32'd4;
                        end else begin
                            state_d = FETCH_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                FETCH_DROP: begin
                    if (mem_ack_i) begin
                        if (can_issue) begin
                            state_d = FETCH_REQ;
                            addr_d  = pc_q;
                        end else begin
                            state_d = FETCH_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = FETCH_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            hold_q  <= hold_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .data_i  ({addr_q, mem_rdata_i}),
        .head_o  (head),
        .count_o (count)
    );

    // While empty the output fields keep showing the last head entry.
    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign out_valid_o = !empty;
    assign out_pc_o    = empty ? hold_q.pc   : head.pc;
    assign out_inst_o  = empty ? hold_q.inst : head.inst;

endmodule
